// File: rtl/midi_pkg.sv
// Shared types and MIDI byte-class constants for the MIDI receive path.
package midi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BITS,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [3:0] STATUS_PROG     = 4'hC;
    localparam logic [3:0] STATUS_CHPRESS  = 4'hD;
    localparam logic [7:0] SYS_BASE        = 8'hF0;
    localparam logic [7:0] RT_BASE         = 8'hF8;

    // Program change and channel pressure carry a single data byte.
    function automatic logic single_data(input logic [7:0] status);
        return (status[7:4] == STATUS_PROG) || (status[7:4] == STATUS_CHPRESS);
    endfunction

endpackage

// File: rtl/midi_msg_assembler.sv
// Builds channel-voice messages from framed bytes with running status and tracks
// the currently sounding note for the LED display.
module midi_msg_assembler
    import midi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       msg_valid_o,
    output logic [7:0] status_o,
    output logic [7:0] data1_o,
    output logic [7:0] data2_o,
    output logic [7:0] led_o
);

    logic [7:0] run_q, run_d;
    logic       have_d1_q, have_d1_d;
    logic [7:0] d1_buf_q, d1_buf_d;
    logic       msg_valid_q, msg_valid_d;
    logic [7:0] status_q, status_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;
    logic [7:0] led_q, led_d;
    logic [7:0] msg_d1, msg_d2;

    always_comb begin
        run_d       = run_q;
        have_d1_d   = have_d1_q;
        d1_buf_d    = d1_buf_q;
        msg_valid_d = 1'b0;
        status_d    = status_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        led_d       = led_q;
        msg_d1      = byte_i;
        msg_d2      = 8'h00;
        if (have_d1_q) begin
            msg_d1 = d1_buf_q;
            msg_d2 = byte_i;
        end

        // Realtime bytes fall through untouched so they can interleave with a message.
        if (byte_valid_i && (byte_i < RT_BASE)) begin
            if (byte_i >= SYS_BASE) begin
                run_d     = 8'h00;
                have_d1_d = 1'b0;
            end else if (byte_i[7]) begin
                run_d     = byte_i;
                have_d1_d = 1'b0;
            end else if (run_q != 8'h00) begin
                if (!have_d1_q && !single_data(run_q)) begin
                    d1_buf_d  = byte_i;
                    have_d1_d = 1'b1;
                end else begin
                    msg_valid_d = 1'b1;
                    status_d    = run_q;
                    data1_d     = msg_d1;
                    data2_d     = msg_d2;
                    have_d1_d   = 1'b0;
                    if ((run_q[7:4] == STATUS_NOTE_ON) && (msg_d2 != 8'h00)) begin
                        led_d = msg_d1;
                    end else if (((run_q[7:4] == STATUS_NOTE_OFF) ||
                                  (run_q[7:4] == STATUS_NOTE_ON)) && (msg_d1 == led_q)) begin
                        led_d = 8'h00;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q       <= 8'h00;
            have_d1_q   <= 1'b0;
            d1_buf_q    <= 8'h00;
            msg_valid_q <= 1'b0;
            status_q    <= 8'h00;
            data1_q     <= 8'h00;
            data2_q     <= 8'h00;
            led_q       <= 8'h00;
        end else begin
            run_q       <= run_d;
            have_d1_q   <= have_d1_d;
            d1_buf_q    <= d1_buf_d;
            msg_valid_q <= msg_valid_d;
            status_q    <= status_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            led_q       <= led_d;
        end
    end

    assign msg_valid_o = msg_valid_q;
    assign status_o    = status_q;
    assign data1_o     = data1_q;
    assign data2_o     = data2_q;
    assign led_o       = led_q;

endmodule

// File: rtl/midi_rx_ctrl.sv
// MIDI serial receiver: synchronises DATA, frames 8N1 bytes with mid-bit sampling
// and hands framed bytes to the message assembler.
module midi_rx_ctrl
    import midi_pkg::*;
#(
    parameter int unsigned OSR         = 128,
    parameter int unsigned SAMPLE_PT   = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA,
    output logic       BYTE_VALID,
    output logic [7:0] BYTE,
    output logic       FRAME_ERR,
    output logic       MSG_VALID,
    output logic [7:0] STATUS,
    output logic [7:0] DATA1,
    output logic [7:0] DATA2,
    output logic       BUSY,
    output logic [7:0] LED
);

    localparam int unsigned TW = $clog2(OSR);
    localparam logic [TW-1:0] TimerMax  = TW'(OSR - 1);
    localparam logic [TW-1:0] SampleCnt = TW'(SAMPLE_PT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          timer_q, timer_d;
    rx_state_t              state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic                   data_s;
    logic                   strobe;

    assign data_s = sync_q[SYNC_STAGES-1];
    assign strobe = (timer_q == SampleCnt);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], DATA};

        if ((state_q == IDLE) && !data_s) begin
            timer_d = '0;
        end else if (timer_q == TimerMax) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!data_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (strobe) begin
                    if (data_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = BITS;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            BITS: begin
                if (strobe) begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (strobe) begin
                    if (data_s) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (data_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q       <= '1;
            timer_q      <= '0;
            state_q      <= IDLE;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            timer_q      <= timer_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign BYTE_VALID = byte_valid_q;
    assign BYTE       = byte_q;
    assign FRAME_ERR  = frame_err_q;
    assign BUSY       = busy_q;

    midi_msg_assembler u_msg_assembler (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .byte_i       (byte_q),
        .byte_valid_i (byte_valid_q),
        .msg_valid_o  (MSG_VALID),
        .status_o     (STATUS),
        .data1_o      (DATA1),
        .data2_o      (DATA2),
        .led_o        (LED)
    );

endmodule
